// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 keystream XOR stage.
//   state_e : control FSM states of rc4_xor_stage
//   byte_t  : 8-bit data byte
//   DEFAULT_* : default parameter values for the stage and its FIFO
package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrop,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_DROP_N     = 0;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam int unsigned DEFAULT_LEN_W      = 16;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Synchronous keystream FIFO, 8-bit entries, async active-high reset.
//   clk, rst       : clock, asynchronous reset
//   flush          : synchronous clear of all entries
//   wr_en, wr_data : push request (ignored when full)
//   rd_en, rd_data : pop request (ignored when empty); rd_data is the current head
//   count          : number of stored entries
//   full, empty    : occupancy flags
// A push into an empty FIFO is visible at the head only from the next cycle.
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  byte_t                    wr_data,
    input  logic                     rd_en,
    output byte_t                    rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Storage needs no reset: it is only read while count_q is nonzero.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + CW'(1);
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rc4_xor_stage.sv
// RC4 output stage: buffers keystream, optionally drops the first DROP_N bytes
// after each start, and XORs each remaining keystream byte with one data byte.
//   clk, rst                       : clock, asynchronous active-high reset
//   start, msg_len                 : begin a message of msg_len bytes (IDLE only)
//   ks_data, ks_valid, ks_ready    : keystream input handshake
//   din, din_valid, din_ready      : data input handshake
//   dout, dout_valid, dout_ready   : registered output handshake
//   dout_last                      : final byte of the message
//   busy                           : not idle
//   done                           : one-cycle pulse when the message completes
module rc4_xor_stage
    import rc4_pkg::*;
#(
    parameter int unsigned DROP_N     = DEFAULT_DROP_N,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned LEN_W      = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  byte_t            ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  byte_t            din,
    input  logic             din_valid,
    output logic             din_ready,
    output byte_t            dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    localparam int unsigned DROP_LAST_I = (DROP_N > 0) ? DROP_N - 1 : 0;
    localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_LAST_I);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    byte_t               dout_q;
    logic                dout_valid_q;
    logic                dout_last_q;
    logic                done_q, done_d;

    logic                fifo_flush;
    logic                fifo_push;
    logic                fifo_pop;
    byte_t               fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                unused_fifo_count;

    logic                out_free;
    logic                load;
    logic                load_last;

    assign unused_fifo_count = ^fifo_count;

    // Output register can take a new byte if it is empty or drains this cycle.
    assign out_free = !dout_valid_q || dout_ready;

    rc4_ks_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush),
        .wr_en   (fifo_push),
        .wr_data (ks_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        drop_cnt_d = drop_cnt_q;
        done_d     = 1'b0;
        ks_ready   = 1'b0;
        din_ready  = 1'b0;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        load_last  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d      = msg_len;
                    byte_cnt_d = '0;
                    drop_cnt_d = '0;
                    fifo_flush = 1'b1;
                    if (DROP_N > 0) begin
                        state_d = StDrop;
                    end else if (msg_len != '0) begin
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDrop: begin
                // Dropped bytes never enter the FIFO.
                ks_ready = 1'b1;
                if (ks_valid) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                    if (drop_cnt_q == DROP_LAST) begin
                        state_d = (len_q == '0) ? StDone : StRun;
                    end
                end
            end
            StRun: begin
                // Readies depend only on registered state and dout_ready.
                ks_ready  = !fifo_full;
                fifo_push = ks_valid && !fifo_full;
                din_ready = !fifo_empty && out_free;
                if (din_valid && din_ready) begin
                    fifo_pop   = 1'b1;
                    load       = 1'b1;
                    load_last  = (byte_cnt_q == len_q - LEN_W'(1));
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    if (load_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            byte_cnt_q <= '0;
            drop_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else if (load) begin
            dout_q       <= din ^ fifo_head;
            dout_valid_q <= 1'b1;
            dout_last_q  <= load_last;
        end else if (dout_ready) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

endmodule

// File: tb/tb_rc4_xor_stage.sv
// Directed bench for rc4_xor_stage: two instances (DROP_N=0 and DROP_N=3)
// share the stimulus; sel picks which one is started and observed.
module tb_rc4_xor_stage;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [15:0] msg_len;
    byte_t       ks_data;
    logic        ks_valid;
    byte_t       din;
    logic        din_valid;
    logic        dout_ready;

    logic  ks_ready0, din_ready0, dout_valid0, dout_last0, busy0, done0;
    logic  ks_ready3, din_ready3, dout_valid3, dout_last3, busy3, done3;
    byte_t dout0, dout3;

    logic  ks_ready, din_ready, dout_valid, dout_last, busy, done;
    byte_t dout;

    int n_checks = 0;
    int n_fail   = 0;

    byte_t ks_vec [16];
    byte_t din_vec [16];
    byte_t out_q [$];
    bit    last_q [$];
    int    ks_hs, pre_dr_hs, done_cnt, ks_hs_at_din;
    logic  ks_ready_at_din;

    always #5 clk = ~clk;

    rc4_xor_stage #(
        .DROP_N     (0),
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start && !sel),
        .msg_len    (msg_len),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready0),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready0),
        .dout       (dout0),
        .dout_valid (dout_valid0),
        .dout_ready (dout_ready),
        .dout_last  (dout_last0),
        .busy       (busy0),
        .done       (done0)
    );

    rc4_xor_stage #(
        .DROP_N     (3),
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start && sel),
        .msg_len    (msg_len),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready3),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready3),
        .dout       (dout3),
        .dout_valid (dout_valid3),
        .dout_ready (dout_ready),
        .dout_last  (dout_last3),
        .busy       (busy3),
        .done       (done3)
    );

    assign ks_ready   = sel ? ks_ready3   : ks_ready0;
    assign din_ready  = sel ? din_ready3  : din_ready0;
    assign dout       = sel ? dout3       : dout0;
    assign dout_valid = sel ? dout_valid3 : dout_valid0;
    assign dout_last  = sel ? dout_last3  : dout_last0;
    assign busy       = sel ? busy3       : busy0;
    assign done       = sel ? done3       : done0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Byte vectors are given MSB-first: the first byte is the leftmost.
    task automatic set_vec(input logic [127:0] ks, input logic [127:0] dn, input int n);
        for (int i = 0; i < 16; i++) begin
            ks_vec[i]  = (i < n) ? ks[8*(n-1-i) +: 8] : 8'h00;
            din_vec[i] = (i < n) ? dn[8*(n-1-i) +: 8] : 8'h00;
        end
    endtask

    task automatic check_out(input string tag, input logic [127:0] exp, input int n);
        logic [7:0] e;
        check_eq({tag, "_count"}, out_q.size(), n);
        for (int i = 0; i < n; i++) begin
            e = exp[8*(n-1-i) +: 8];
            check_eq($sformatf("%s_b%0d", tag, i), (i < out_q.size()) ? out_q[i] : 8'hxx, e);
            check_eq($sformatf("%s_last%0d", tag, i),
                     (i < last_q.size()) ? 32'(last_q[i]) : 32'hx, (i == n - 1) ? 1 : 0);
        end
    endtask

    // One message. Inputs change at negedge; handshakes are evaluated #1 later
    // (readies do not depend on valids) and take effect at the next posedge.
    task automatic run_msg(input int len, input int ks_n, input int din_n, input int din_from,
                           input int stall_from, input int stall_len, input int restart_at,
                           input int max_cycles, input bit expect_done);
        int    ki, di, post;
        bit    seen_dr, stalled;
        byte_t held_dout;
        logic  held_last, held_valid;
        ki = 0; di = 0; post = 0; seen_dr = 0;
        held_dout = '0; held_last = 1'b0; held_valid = 1'b0;
        out_q.delete(); last_q.delete();
        ks_hs = 0; pre_dr_hs = 0; done_cnt = 0; ks_hs_at_din = -1; ks_ready_at_din = 1'b1;
        @(negedge clk);
        msg_len = 16'(len);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (done) done_cnt++;
            if (done_cnt > 0) begin
                post++;
                if (post > 2) break;
            end
            stalled = (c >= stall_from) && (c < stall_from + stall_len);
            if (c == stall_from) begin
                held_dout  = dout;
                held_last  = dout_last;
                held_valid = dout_valid;
            end else if (stalled && held_valid) begin
                check_eq("stall_dout", dout, held_dout);
                check_eq("stall_last", dout_last, held_last);
                check_eq("stall_valid", dout_valid, 1);
            end
            if (c == restart_at) msg_len = 16'd2;
            start      = (c == restart_at);
            ks_valid   = (ki < ks_n);
            ks_data    = (ki < 16) ? ks_vec[ki] : 8'h00;
            din_valid  = (c >= din_from) && (di < din_n);
            din        = (di < 16) ? din_vec[di] : 8'h00;
            dout_ready = !stalled;
            #1;
            if (c == din_from) begin
                ks_hs_at_din    = ks_hs;
                ks_ready_at_din = ks_ready;
            end
            if (dout_valid && !dout_ready) check_eq("stall_din_ready", din_ready, 0);
            if (din_ready) seen_dr = 1'b1;
            if (ks_valid && ks_ready) begin
                ki++;
                ks_hs++;
                if (!seen_dr) pre_dr_hs++;
            end
            if (din_valid && din_ready) di++;
            if (dout_valid && dout_ready) begin
                out_q.push_back(dout);
                last_q.push_back(dout_last);
            end
            @(negedge clk);
        end
        start      = 1'b0;
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        if (expect_done) check_eq("done_pulses", done_cnt, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ks_ready"}, ks_ready, 0);
        check_eq({tag, "_din_ready"}, din_ready, 0);
        check_eq({tag, "_dout"}, dout, 0);
        check_eq({tag, "_dout_valid"}, dout_valid, 0);
        check_eq({tag, "_dout_last"}, dout_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    localparam logic [127:0] KV_KS   = 128'h00000000000000EB9F7781B734CA72A7;
    localparam logic [127:0] KV_DIN  = 128'h00000000000000506C61696E74657874;
    localparam logic [127:0] KV_DOUT = 128'h00000000000000BBF316E8D940AF0AD3;

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; msg_len = '0;
        ks_data = '0; ks_valid = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        sel = 1'b1;
        #1;
        check_all_zero("reset3");
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Known "Key"/"Plaintext" vector.
        set_vec(KV_KS, KV_DIN, 9);
        run_msg(9, 9, 9, 0, 1000, 0, -1, 100, 1'b1);
        check_out("kv", KV_DOUT, 9);

        // Same vector, 5-cycle sink stall and an ignored start during RUN.
        run_msg(9, 9, 9, 0, 4, 5, 2, 100, 1'b1);
        check_out("bp", KV_DOUT, 9);

        // FIFO fill with no data: exactly 4 keystream bytes accepted, kept in order.
        set_vec(128'h0000000000000000A1B2C3D4E5F60718, 128'h0, 8);
        run_msg(4, 8, 4, 10, 1000, 0, -1, 100, 1'b1);
        check_eq("full_hs", ks_hs_at_din, 4);
        check_eq("full_ks_ready", ks_ready_at_din, 0);
        check_out("full", 128'hA1B2C3D4, 4);

        // RC4-drop with DROP_N=3: 3 discarded, then one buffered byte before din_ready.
        sel = 1'b1;
        set_vec(128'h1122334455, 128'h0, 5);
        run_msg(2, 5, 2, 0, 1000, 0, -1, 100, 1'b1);
        check_out("drop", 128'h4455, 2);
        check_eq("drop_pre_hs", pre_dr_hs, 4);
        check_eq("drop_total_hs", ks_hs, 5);
        sel = 1'b0;

        // Zero-length message: no handshakes, done two cycles after start.
        @(negedge clk);
        msg_len = '0; start = 1'b1; ks_valid = 1'b1; din_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("zero_busy1", busy, 1);
        check_eq("zero_done1", done, 0);
        check_eq("zero_ks_ready1", ks_ready, 0);
        check_eq("zero_din_ready1", din_ready, 0);
        @(negedge clk);
        #1;
        check_eq("zero_done2", done, 1);
        check_eq("zero_busy2", busy, 0);
        check_eq("zero_ks_ready2", ks_ready, 0);
        @(negedge clk);
        #1;
        check_eq("zero_done3", done, 0);
        ks_valid = 1'b0; din_valid = 1'b0;

        // Reset mid-RUN while the output register is full and stalled.
        set_vec(KV_KS, KV_DIN, 9);
        run_msg(9, 9, 9, 0, 0, 100, -1, 4, 1'b0);
        check_eq("pre_rst_valid", dout_valid, 1);
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_msg(9, 9, 9, 0, 1000, 0, -1, 100, 1'b1);
        check_out("after_rst", KV_DOUT, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
